// File: rtl/msdap_fir_sequencer.sv
// Per-channel MSDAP FIR sequencer: walks rj groups and coefficients, fetches
// delayed samples and shift-adds them into a 40-bit accumulator per frame.
module msdap_fir_sequencer #(
   parameter int NRJ     = 16,
   parameter int NCOEF   = 512,
   parameter int HIST_AW = 8,
   parameter int ACC_W   = 40
) (
   input  logic                       sclk,
   input  logic                       reset,
   input  logic                       start_frame,
   input  logic [HIST_AW-1:0]         new_ptr,
   input  logic                       clear,
   output logic [$clog2(NRJ)-1:0]     rj_addr,
   input  logic [15:0]                rj_data,
   output logic [$clog2(NCOEF)-1:0]   coef_addr,
   input  logic [15:0]                coef_data,
   output logic [HIST_AW-1:0]         x_addr,
   input  logic [15:0]                x_data,
   output logic [ACC_W-1:0]           y,
   output logic                       y_valid,
   output logic                       busy,
   output logic                       overrun,
   output logic [2:0]                 dbg_state
);

   localparam int RJ_AW = $clog2(NRJ);
   localparam int C_AW  = $clog2(NCOEF);

   typedef enum logic [2:0] {
      S_IDLE, S_RJ_REQ, S_RJ_WAIT, S_TERMS, S_DRAIN, S_SHIFT, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [RJ_AW-1:0]        j;
   logic [C_AW-1:0]         c;
   logic [9:0]              count;
   logic [HIST_AW-1:0]      new_ptr_q;
   logic [HIST_AW-1:0]      n_cnt, n_cnt_inc, n_q;
   logic signed [ACC_W-1:0] acc, x_ext;
   logic                    accept;
   logic                    v1, v2, v3, s2, s3, m2, m3;
   logic [7:0]              k;
   logic                    unused_bits;

   assign unused_bits = &{1'b0, rj_data[15:10], coef_data[15:9]};

   assign rj_addr   = j;
   assign coef_addr = c;
   assign busy      = (state != S_IDLE);
   assign y_valid   = (state == S_DONE);
   assign dbg_state = state;
   assign k         = coef_data[7:0];
   assign x_ext     = {{(ACC_W-32){x_data[15]}}, x_data, 16'b0};
   assign n_cnt_inc = (n_cnt == '1) ? n_cnt : n_cnt + 1'b1;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: if (start_frame) begin
            accept    = 1'b1;
            state_nxt = S_RJ_REQ;
         end
         S_RJ_REQ:  state_nxt = S_RJ_WAIT;
         S_RJ_WAIT: state_nxt = (rj_data[9:0] == 10'd0) ? S_SHIFT : S_TERMS;
         S_TERMS:   if (count == 10'd1) state_nxt = S_DRAIN;
         // v3 retires on the same edge that leaves DRAIN, so SHIFT sees the final sum
         S_DRAIN:   if (!v1 && !v2) state_nxt = S_SHIFT;
         S_SHIFT:   state_nxt = (j == RJ_AW'(NRJ-1)) ? S_DONE : S_RJ_REQ;
         S_DONE: begin
            if (start_frame) begin
               accept    = 1'b1;
               state_nxt = S_RJ_REQ;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (clear) begin
         accept    = 1'b0;
         state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge sclk) begin
      if (!reset) begin
         state     <= S_IDLE;
         y         <= '0;
         overrun   <= 1'b0;
         j         <= '0;
         c         <= '0;
         count     <= '0;
         x_addr    <= '0;
         new_ptr_q <= '0;
         n_cnt     <= '0;
         n_q       <= '0;
         acc       <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         m2        <= 1'b0;
         m3        <= 1'b0;
      end else begin
         state   <= state_nxt;
         overrun <= start_frame && !clear && !accept;

         // Term pipeline: coef_data -> x_addr -> x_data -> accumulate
         v1 <= (state == S_TERMS) && !clear;
         v2 <= v1 && !clear;
         v3 <= v2 && !clear;
         if (v1) begin
            x_addr <= new_ptr_q - HIST_AW'(k);
            s2     <= coef_data[8];
            m2     <= (HIST_AW'(k) > n_q);
         end
         s3 <= s2;
         m3 <= m2;
         if (v3 && !m3) acc <= s3 ? acc - x_ext : acc + x_ext;

         case (state)
            S_RJ_WAIT: count <= rj_data[9:0];
            S_TERMS: begin
               c     <= c + 1'b1;
               count <= count - 1'b1;
            end
            S_SHIFT: begin
               acc <= acc >>> 1;
               if (j == RJ_AW'(NRJ-1)) y <= acc >>> 1;
               else                    j <= j + 1'b1;
            end
            default: ;
         endcase

         if (accept) begin
            new_ptr_q <= new_ptr;
            acc       <= '0;
            j         <= '0;
            c         <= '0;
            n_cnt     <= n_cnt_inc;
            n_q       <= n_cnt_inc - 1'b1;
         end
         if (clear) n_cnt <= '0;
      end
   end

endmodule
